// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one external bus between instruction fetch and
// load/store, with data-burst fairness toward fetch and a bus-busy timeout.
module mem_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,
    output logic        instr_valid,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        err,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic        grant_data,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] MAX_BURST_V = 3'(MAX_DATA_BURST);
    localparam logic [7:0] TIMEOUT_V   = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_burst_cnt;
    logic [7:0]  r_wait_cnt;
    logic        r_op_write;
    logic        r_grant_data;
    logic [31:0] r_instr_rdata;
    logic [31:0] r_data_rdata;
    logic        r_instr_valid;
    logic        r_data_valid;
    logic        r_err;
    logic        r_bus_read;
    logic        r_bus_write;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic w_data_req;
    logic w_any_req;
    logic w_pick_instr;
    logic w_pick_write;
    logic w_timeout;
    logic w_wait_done;

    assign w_data_req   = data_read | data_write;
    assign w_any_req    = instr_req | w_data_req;
    // Fetch only wins a contested grant once the data port has used up its burst allowance.
    assign w_pick_instr = instr_req & (~w_data_req | (r_burst_cnt == MAX_BURST_V));
    assign w_pick_write = ~w_pick_instr & data_write;
    assign w_timeout    = bus_busy & (r_wait_cnt == TIMEOUT_V);
    assign w_wait_done  = ~bus_busy | w_timeout;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (w_wait_done) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_burst_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_op_write    <= 1'b0;
            r_grant_data  <= 1'b0;
            r_instr_rdata <= '0;
            r_data_rdata  <= '0;
            r_instr_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            r_err         <= 1'b0;
            r_bus_read    <= 1'b0;
            r_bus_write   <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
        end else begin
            // Strobes, valids and err are single-cycle pulses.
            r_bus_read    <= 1'b0;
            r_bus_write   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            r_err         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_data <= ~w_pick_instr;
                        r_op_write   <= w_pick_write;
                        r_bus_read   <= ~w_pick_write;
                        r_bus_write  <= w_pick_write;
                        r_bus_addr   <= w_pick_instr ? instr_addr : data_addr;
                        r_bus_wdata  <= w_pick_write ? data_wdata : 32'd0;
                        if (w_pick_instr || !instr_req) begin
                            r_burst_cnt <= '0;
                        end else if (r_burst_cnt != MAX_BURST_V) begin
                            r_burst_cnt <= r_burst_cnt + 3'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_err <= w_timeout;
                        if (r_grant_data) begin
                            r_data_valid <= 1'b1;
                            if (!r_op_write) r_data_rdata <= w_timeout ? 32'd0 : bus_rdata;
                        end else begin
                            r_instr_valid <= 1'b1;
                            r_instr_rdata <= w_timeout ? 32'd0 : bus_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_rdata = r_instr_rdata;
    assign instr_valid = r_instr_valid;
    assign data_rdata  = r_data_rdata;
    assign data_valid  = r_data_valid;
    assign err         = r_err;
    assign bus_read    = r_bus_read;
    assign bus_write   = r_bus_write;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign grant_data  = r_grant_data;
    assign state       = r_state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter for the RV32I core. It shares the single external memory bus between the instruction-fetch port and the load/store data port, and sequences each access through a request / strobe / busy-wait / completion handshake. It sits between the fetch and load/store units and the memory controller's bus side. It also enforces fetch fairness and a bus timeout so that a hung bus cannot stall the core forever.

## Interface
Parameters:
- MAX_DATA_BURST, default 4: maximum consecutive data grants while instr_req is pending. Legal range is 1..7.
- TIMEOUT, default 255: maximum bus_busy-high cycles tolerated in WAIT. Legal range is 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- nrst  in  1  asynchronous, active-low reset
- instr_req  in  1  fetch request; held high until instr_valid
- instr_addr  in  32  fetch address
- instr_rdata  out  32  fetched word; updated on completion, held otherwise
- instr_valid  out  1  one-cycle completion pulse for fetch
- data_read  in  1  load request; held high until data_valid
- data_write  in  1  store request; held high until data_valid
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_rdata  out  32  load result; updated only on read completion
- data_valid  out  1  one-cycle completion pulse for load/store
- err  out  1  timeout flag; meaningful only while a valid pulse is high
- bus_read  out  1  one-cycle read strobe
- bus_write  out  1  one-cycle write strobe
- bus_addr  out  32  registered bus address
- bus_wdata  out  32  registered bus write data
- bus_rdata  in  32  bus read data; sampled when bus_busy is low in WAIT
- bus_busy  in  1  bus transaction in progress
- grant_data  out  1  current or last owner (1 = data, 0 = instr)
- state  out  2  FSM state, for debug: IDLE=0, ISSUE=1, WAIT=2, DONE=3

## Operation
- FSM transitions:
  - IDLE → ISSUE when any request is high; the winner is chosen and its address and write data are latched into bus_addr and bus_wdata.
  - ISSUE → WAIT unconditionally.
  - WAIT → DONE when bus_busy is low, or when the timeout fires.
  - DONE → IDLE unconditionally.
- Arbitration in IDLE:
  - The data port wins over fetch by default.
  - Fetch wins if burst_cnt == MAX_DATA_BURST and instr_req is high.
  - Only a single requester → that requester wins.
- burst_cnt:
  - Increments on each data grant made while instr_req is high; saturates at MAX_DATA_BURST.
  - Clears on any instr grant, and on a data grant made while instr_req is low.
- Read/write conflict: if data_read and data_write are both high, it is treated as a write.
- Bus strobes:
  - bus_read or bus_write is high only in ISSUE, matching the latched operation. A fetch is always a read.
  - bus_wdata carries the store data for writes and 0 for reads.
  - bus_addr and bus_wdata hold their values until the next grant.
- Completion:
  - In WAIT with bus_busy low, a read loads bus_rdata into the owner's rdata register; a write leaves data_rdata unchanged.
  - In DONE, the owner's valid output is high for exactly one cycle.
- Timeout:
  - wait_cnt clears in ISSUE and increments on each WAIT cycle with bus_busy high.
  - When wait_cnt reaches TIMEOUT, the FSM moves to DONE with err=1 and the owner's rdata is set to 0 for a read.
  - Otherwise err=0 in DONE.
- Requester rule: a requester drops its request in the cycle after its valid pulse. A request still high in IDLE is treated as a new request.

## Timing
- Reset (nrst low, asynchronous, at any time including mid-transaction):
  - State → IDLE; the pending access is abandoned.
  - All outputs are 0: rdata, valids, err, strobes, bus_addr, bus_wdata, grant_data, state.
  - burst_cnt = 0 and wait_cnt = 0.
- Zero-wait bus (request first seen high in IDLE cycle N):
  - ISSUE with strobe at N+1.
  - WAIT at N+2.
  - DONE with valid at N+3.
  - IDLE at N+4.
  - Latency from request to valid is 3 cycles.
- Each additional bus_busy-high cycle in WAIT adds 1 cycle to that latency.
- Timeout: with bus_busy held high, valid with err=1 arrives at N+3+TIMEOUT.
- Back-to-back accesses: a new grant is possible in the IDLE cycle N+4, so peak throughput is one access per 4 cycles.
- Request changes outside IDLE are ignored. The addresses latched at grant are used for the whole transaction.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-access: grant a fetch, assert nrst low during WAIT → state=0, bus_read=0, instr_valid=0, bus_addr=0 immediately; IDLE after release.
- Single fetch, addr 0x0000_0040, bus_busy low, bus_rdata 0x0051_0113 → bus_read pulses at N+1 with bus_addr 0x40; instr_valid at N+3 with instr_rdata 0x0051_0113 and err=0.
- Store addr 0x100, wdata 0xDEAD_BEEF, with bus_busy high for 3 WAIT cycles → bus_write pulses with bus_wdata 0xDEADBEEF; data_valid at N+6; data_rdata unchanged.
- Simultaneous instr_req and data_read held continuously, MAX_DATA_BURST=4 → grant order D,D,D,D,I,D,D,D,D,I (grant_data sampled in ISSUE).
- TIMEOUT=5, load with bus_busy stuck high → data_valid at N+8 with err=1 and data_rdata=0; next access proceeds normally.
- data_read and data_write both high → bus_write pulses, bus_read stays 0.
